// File: rtl/xbar_pkg.sv
// Shared helpers for the LUT-tile crossbar: width derivations and the config
// loader state encoding.
package xbar_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } ld_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int sel_w(input int n_in);
        return clog2(n_in);
    endfunction

    function automatic int cfg_bits(input int n_in, input int n_out);
        return n_out * sel_w(n_in);
    endfunction

    function automatic int n_words(input int n_in, input int n_out, input int cfg_w);
        return (cfg_bits(n_in, n_out) + cfg_w - 1) / cfg_w;
    endfunction

endpackage

// File: rtl/cfg_xbar_loader.sv
// Config loader: accepts CFG_W-bit words into a shadow register, least
// significant word first, and releases a commit strobe once the shadow is full.
module cfg_xbar_loader
    import xbar_pkg::*;
#(
    parameter int N_IN  = 18,
    parameter int N_OUT = 20,
    parameter int CFG_W = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cfg_valid_i,
    output logic                               cfg_ready_o,
    input  logic [CFG_W-1:0]                   cfg_data_i,
    input  logic                               cfg_commit_i,
    output logic                               cfg_full_o,
    output logic                               cfg_done_o,
    output logic                               commit_o,
    output logic [cfg_bits(N_IN, N_OUT)-1:0]   shadow_o
);

    localparam int CFG_BITS = cfg_bits(N_IN, N_OUT);
    localparam int N_WORDS  = n_words(N_IN, N_OUT, CFG_W);
    localparam int CNT_W    = clog2(N_WORDS + 1);

    ld_state_e           state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CFG_BITS-1:0] shadow_q;
    logic                ready_q;
    logic                full_q;
    logic                done_q;

    logic                accept_s;
    logic                last_s;
    logic                commit_s;

    always_comb begin
        accept_s = cfg_valid_i && ready_q;
        last_s   = (cnt_q == CNT_W'(N_WORDS - 1));
        commit_s = cfg_commit_i && (state_q == FULL);
    end

    // Loader FSM; a commit arriving while still loading is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            shadow_q <= '0;
            ready_q  <= 1'b1;
            full_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= commit_s;
            case (state_q)
                LOAD: begin
                    if (accept_s) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_s) begin
                            state_q <= FULL;
                            ready_q <= 1'b0;
                            full_q  <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (commit_s) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        full_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= LOAD;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    full_q  <= 1'b0;
                end
            endcase
            // Bits of the final word beyond CFG_BITS have no home and are dropped.
            for (int b = 0; b < CFG_BITS; b++) begin
                if (accept_s && (cnt_q == CNT_W'(b / CFG_W))) begin
                    shadow_q[b] <= cfg_data_i[b % CFG_W];
                end
            end
        end
    end

    assign cfg_ready_o = ready_q;
    assign cfg_full_o  = full_q;
    assign cfg_done_o  = done_q;
    assign commit_o    = commit_s;
    assign shadow_o    = shadow_q;

endmodule

// File: rtl/cfg_xbar.sv
// LUT-tile crossbar: each output picks one input through a select field held in
// an active config register that is atomically refreshed from the loader.
module cfg_xbar
    import xbar_pkg::*;
#(
    parameter int N_IN    = 18,
    parameter int N_OUT   = 20,
    parameter int CFG_W   = 8,
    parameter bit REG_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IN-1:0]   io_xbar_in,
    output logic [N_OUT-1:0]  io_xbar_out,
    input  logic              io_cfg_valid,
    output logic              io_cfg_ready,
    input  logic [CFG_W-1:0]  io_cfg_data,
    input  logic              io_cfg_commit,
    output logic              io_cfg_full,
    output logic              io_cfg_done,
    output logic              io_sel_err
);

    localparam int SEL_W    = sel_w(N_IN);
    localparam int CFG_BITS = cfg_bits(N_IN, N_OUT);

    logic                commit_s;
    logic [CFG_BITS-1:0] shadow_s;
    logic [CFG_BITS-1:0] active_q;
    logic                sel_err_q;
    logic [N_OUT-1:0]    mux_s;
    logic                shadow_err_s;
    logic                hit_s;

    cfg_xbar_loader #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .CFG_W (CFG_W)
    ) u_loader (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid_i  (io_cfg_valid),
        .cfg_ready_o  (io_cfg_ready),
        .cfg_data_i   (io_cfg_data),
        .cfg_commit_i (io_cfg_commit),
        .cfg_full_o   (io_cfg_full),
        .cfg_done_o   (io_cfg_done),
        .commit_o     (commit_s),
        .shadow_o     (shadow_s)
    );

    // Mux array; a field matching no input leaves its output at 0 rather than X.
    always_comb begin
        mux_s = '0;
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (active_q[o*SEL_W +: SEL_W] == SEL_W'(i)) begin
                    mux_s[o] = io_xbar_in[i];
                end
            end
        end
    end

    // Range check on the shadow, so the flag is ready to latch on the commit edge.
    always_comb begin
        shadow_err_s = 1'b0;
        hit_s        = 1'b0;
        for (int o = 0; o < N_OUT; o++) begin
            hit_s = 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                if (shadow_s[o*SEL_W +: SEL_W] == SEL_W'(i)) begin
                    hit_s = 1'b1;
                end
            end
            if (!hit_s) begin
                shadow_err_s = 1'b1;
            end
        end
    end

    // Active config and its error flag change only on a commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= '0;
            sel_err_q <= 1'b0;
        end else if (commit_s) begin
            active_q  <= shadow_s;
            sel_err_q <= shadow_err_s;
        end else begin
            active_q  <= active_q;
            sel_err_q <= sel_err_q;
        end
    end

    assign io_sel_err = sel_err_q;

    generate
        if (REG_OUT) begin : g_reg_out
            logic [N_OUT-1:0] out_q;

            // Output stage adds one cycle of latency.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_q <= '0;
                end else begin
                    out_q <= mux_s;
                end
            end

            assign io_xbar_out = out_q;
        end else begin : g_comb_out
            assign io_xbar_out = mux_s;
        end
    endgenerate

endmodule

// File: tb/tb_cfg_xbar.sv
// Randomised self-checking bench for cfg_xbar: default build plus a small
// combinational-output build, both checked against a select-table model.
module tb_cfg_xbar;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [17:0] b_in;
    logic [19:0] b_out;
    logic        b_valid, b_ready, b_commit, b_full, b_done, b_err;
    logic [7:0]  b_data;

    logic [3:0]  s_in;
    logic [2:0]  s_out;
    logic        s_valid, s_ready, s_commit, s_full, s_done, s_err;
    logic [0:0]  s_data;

    int n_checks = 0;
    int n_pass   = 0;

    // committed select tables and pending (being loaded) tables
    int bsel[20];
    int bpend[20];
    int ssel[3];
    int spend[3];

    cfg_xbar dut_big (
        .clk(clk), .reset(reset), .io_xbar_in(b_in), .io_xbar_out(b_out),
        .io_cfg_valid(b_valid), .io_cfg_ready(b_ready), .io_cfg_data(b_data),
        .io_cfg_commit(b_commit), .io_cfg_full(b_full), .io_cfg_done(b_done),
        .io_sel_err(b_err)
    );

    cfg_xbar #(.N_IN(4), .N_OUT(3), .CFG_W(1), .REG_OUT(1'b0)) dut_small (
        .clk(clk), .reset(reset), .io_xbar_in(s_in), .io_xbar_out(s_out),
        .io_cfg_valid(s_valid), .io_cfg_ready(s_ready), .io_cfg_data(s_data),
        .io_cfg_commit(s_commit), .io_cfg_full(s_full), .io_cfg_done(s_done),
        .io_sel_err(s_err)
    );

    function automatic logic [19:0] exp_big(input logic [17:0] x);
        logic [19:0] e;
        e = 20'd0;
        for (int o = 0; o < 20; o++) begin
            if (bsel[o] < 18) e[o] = x[bsel[o]];
        end
        return e;
    endfunction

    function automatic logic exp_big_err();
        logic e;
        e = 1'b0;
        for (int o = 0; o < 20; o++) if (bsel[o] >= 18) e = 1'b1;
        return e;
    endfunction

    function automatic logic [103:0] pack_big();
        logic [103:0] v;
        v = 104'd0;
        for (int o = 0; o < 20; o++) v[o*5 +: 5] = 5'(bpend[o]);
        return v;
    endfunction

    function automatic logic [2:0] exp_small(input logic [3:0] x);
        logic [2:0] e;
        e = 3'd0;
        for (int o = 0; o < 3; o++) e[o] = x[ssel[o]];
        return e;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_big(input int first, input int count);
        logic [103:0] cfg;
        cfg = pack_big();
        for (int k = first; k < first + count; k++) begin
            b_valid = 1'b1;
            b_data  = cfg[k*8 +: 8];
            tick(1);
        end
        b_valid = 1'b0;
        b_data  = 8'd0;
    endtask

    task automatic commit_big();
        b_commit = 1'b1;
        tick(1);
        b_commit = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        for (int o = 0; o < 20; o++) bsel[o] = 0;
        for (int o = 0; o < 3; o++) ssel[o] = 0;
    endtask

    task automatic check_big_data(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            b_in = 18'($urandom);
            tick(1);
            n_checks++;
            if (b_out !== exp_big(b_in)) $display("FAIL %s: out=%h expected %h (in=%h)", name, b_out, exp_big(b_in), b_in);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        b_in = 18'd0;
        s_in = 4'b0101;
        do_reset();
        n_checks++;
        if ({b_ready, b_full, b_done, b_err} !== 4'b1000) $display("FAIL reset_flags: rdy/full/done/err=%b expected 1000", {b_ready, b_full, b_done, b_err});
        else n_pass++;
        n_checks++;
        if (b_out !== 20'd0) $display("FAIL reset_out: out=%h expected 00000", b_out);
        else n_pass++;
        n_checks++;
        if (s_out !== 3'b111) $display("FAIL reset_small_out: out=%b expected 111", s_out);
        else n_pass++;
        b_in = 18'h2A5B3;
        #1;
        n_checks++;
        if (b_out !== 20'd0) $display("FAIL reset_latency: out=%h expected 00000 before edge", b_out);
        else n_pass++;
        tick(1);
        n_checks++;
        if (b_out !== 20'hFFFFF) $display("FAIL reset_bit0: out=%h expected fffff", b_out);
        else n_pass++;
    endtask

    task automatic test_identity();
        for (int o = 0; o < 20; o++) bpend[o] = o % 18;
        load_big(0, 13);
        n_checks++;
        if ({b_full, b_ready} !== 2'b10) $display("FAIL ident_full: full/ready=%b expected 10", {b_full, b_ready});
        else n_pass++;
        commit_big();
        bsel = bpend;
        n_checks++;
        if (b_done !== 1'b1) $display("FAIL ident_done: done=%b expected 1", b_done);
        else n_pass++;
        tick(1);
        n_checks++;
        if (b_done !== 1'b0) $display("FAIL ident_done_pulse: done=%b expected 0", b_done);
        else n_pass++;
        check_big_data("ident_map", 4);
        n_checks++;
        if (b_err !== 1'b0) $display("FAIL ident_err: err=%b expected 0", b_err);
        else n_pass++;
    endtask

    task automatic test_partial_commit();
        for (int o = 0; o < 20; o++) bpend[o] = int'($urandom_range(0, 17));
        load_big(0, 12);
        n_checks++;
        if ({b_full, b_ready} !== 2'b01) $display("FAIL partial_state: full/ready=%b expected 01", {b_full, b_ready});
        else n_pass++;
        commit_big();
        n_checks++;
        if (b_done !== 1'b0) $display("FAIL partial_done: done=%b expected 0", b_done);
        else n_pass++;
        check_big_data("partial_oldcfg", 2);
        load_big(12, 1);
        n_checks++;
        if ({b_full, b_ready} !== 2'b10) $display("FAIL partial_full: full/ready=%b expected 10", {b_full, b_ready});
        else n_pass++;
        b_valid = 1'b1;
        b_data  = 8'hFF;
        tick(2);
        b_valid = 1'b0;
        n_checks++;
        if ({b_full, b_ready} !== 2'b10) $display("FAIL partial_extra: full/ready=%b expected 10", {b_full, b_ready});
        else n_pass++;
        commit_big();
        bsel = bpend;
        n_checks++;
        if (b_done !== 1'b1) $display("FAIL partial_commit_done: done=%b expected 1", b_done);
        else n_pass++;
        check_big_data("partial_newcfg", 3);
    endtask

    task automatic test_out_of_range();
        for (int o = 0; o < 20; o++) bpend[o] = o % 18;
        bpend[3] = 31;
        load_big(0, 13);
        commit_big();
        bsel = bpend;
        n_checks++;
        if (b_err !== 1'b1) $display("FAIL oor_err: err=%b expected 1", b_err);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            b_in = 18'($urandom) | 18'h00008;
            tick(1);
            n_checks++;
            if (b_out[3] !== 1'b0 || b_out !== exp_big(b_in)) $display("FAIL oor_out: out=%h expected %h", b_out, exp_big(b_in));
            else n_pass++;
        end
        bpend[3] = 3;
        load_big(0, 13);
        commit_big();
        bsel = bpend;
        n_checks++;
        if (b_err !== 1'b0) $display("FAIL oor_clear: err=%b expected 0", b_err);
        else n_pass++;
        check_big_data("oor_clean_map", 2);
    endtask

    task automatic test_reset_midload();
        for (int o = 0; o < 20; o++) bpend[o] = int'($urandom_range(0, 31));
        load_big(0, 6);
        do_reset();
        n_checks++;
        if ({b_ready, b_full, b_err} !== 3'b100) $display("FAIL midload_reset: rdy/full/err=%b expected 100", {b_ready, b_full, b_err});
        else n_pass++;
        for (int o = 0; o < 20; o++) bpend[o] = int'($urandom_range(0, 31));
        bpend[0] = 5;
        load_big(0, 12);
        n_checks++;
        if (b_full !== 1'b0) $display("FAIL midload_count: full=%b expected 0 after 12 words", b_full);
        else n_pass++;
        load_big(12, 1);
        n_checks++;
        if (b_full !== 1'b1) $display("FAIL midload_full: full=%b expected 1", b_full);
        else n_pass++;
        commit_big();
        bsel = bpend;
        n_checks++;
        if (b_err !== exp_big_err()) $display("FAIL midload_err: err=%b expected %b", b_err, exp_big_err());
        else n_pass++;
        check_big_data("midload_map", 3);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            for (int o = 0; o < 20; o++) bpend[o] = int'($urandom_range(0, 31));
            if (it == 1) for (int o = 0; o < 20; o++) bpend[o] = int'($urandom_range(0, 17));
            load_big(0, 13);
            commit_big();
            bsel = bpend;
            n_checks++;
            if (b_err !== exp_big_err()) $display("FAIL rand_err: err=%b expected %b", b_err, exp_big_err());
            else n_pass++;
            check_big_data("rand_map", 2);
        end
    endtask

    task automatic test_small();
        logic [5:0] cfg;
        for (int it = 0; it < 3; it++) begin
            for (int o = 0; o < 3; o++) spend[o] = int'($urandom_range(0, 3));
            cfg = 6'd0;
            for (int o = 0; o < 3; o++) cfg[o*2 +: 2] = 2'(spend[o]);
            for (int k = 0; k < 6; k++) begin
                s_valid = 1'b1;
                s_data  = cfg[k +: 1];
                tick(1);
            end
            s_valid = 1'b0;
            n_checks++;
            if ({s_full, s_ready} !== 2'b10) $display("FAIL small_full: full/ready=%b expected 10", {s_full, s_ready});
            else n_pass++;
            s_in = 4'($urandom);
            #1;
            n_checks++;
            if (s_out !== exp_small(s_in)) $display("FAIL small_oldcfg: out=%b expected %b", s_out, exp_small(s_in));
            else n_pass++;
            s_commit = 1'b1;
            tick(1);
            s_commit = 1'b0;
            ssel = spend;
            n_checks++;
            if (s_out !== exp_small(s_in) || s_done !== 1'b1) $display("FAIL small_commit: out=%b done=%b expected %b done 1", s_out, s_done, exp_small(s_in));
            else n_pass++;
            for (int i = 0; i < 2; i++) begin
                s_in = 4'($urandom);
                #1;
                n_checks++;
                if (s_out !== exp_small(s_in)) $display("FAIL small_comb: out=%b expected %b", s_out, exp_small(s_in));
                else n_pass++;
            end
            n_checks++;
            if (s_err !== 1'b0) $display("FAIL small_err: err=%b expected 0", s_err);
            else n_pass++;
        end
    endtask

    initial begin
        reset    = 1'b1;
        b_in     = 18'd0;
        b_valid  = 1'b0;
        b_data   = 8'd0;
        b_commit = 1'b0;
        s_in     = 4'd0;
        s_valid  = 1'b0;
        s_data   = 1'b0;
        s_commit = 1'b0;
        #1;
        test_reset();
        test_identity();
        test_partial_commit();
        test_out_of_range();
        test_reset_midload();
        test_random();
        test_small();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
